fft_out_unloader: RTL and testbench
===================================

Name: fft_out_unloader

Overview:
- Output-side consumer of the 8-point FFT final stage.
- Each cycle a handshake occurs, it captures one complete parallel result frame. The frame is y0..y7: y0 and y4 are real only, and bins 1–3 and 5–7 are complex.
- It then streams the frame out one complex bin per beat, in natural order, over a valid/ready interface.
- Two frame banks (ping-pong) let the FFT write the next frame while the current one drains.

Parameters:
- N, 4, data width exponent; every data word is 2**N bits (two's complement), matching the FFT stages.
- HALF, 0, 0 = emit bins 0..7 (8 beats); 1 = emit bins 0..4 only (5 beats, real-input symmetric half).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- y0, y4  input  2**N each  real-only bins 0 and 4.
- yr1, yi1, yr2, yi2, yr3, yi3  input  2**N each  real/imag parts of bins 1, 2, 3.
- yr5, yi5, yr6, yi6, yr7, yi7  input  2**N each  real/imag parts of bins 5, 6, 7.
- in_valid  input  1  frame on the y* inputs is valid.
- in_ready  output  1  a frame bank is free; the frame is captured when in_valid & in_ready at a clk edge.
- out_re  output  2**N  real part of the current bin.
- out_im  output  2**N  imaginary part of the current bin.
- out_idx  output  3  bin index of the current beat.
- out_last  output  1  high on the final beat of the frame (idx 7, or 4 when HALF=1).
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream accepts the beat when out_valid & out_ready at a clk edge.

Behaviour:
- State:
  - bank[0..1]: 14 words each.
  - full[1:0]
  - wr_ptr, rd_ptr: 1 bit each.
  - beat counter cnt: 3 bits.
- Reset (rst=1 at an edge), taking effect the next cycle:
  - full=00, wr_ptr=0, rd_ptr=0, cnt=0.
  - Outputs read out_valid=0, in_ready=1, out_idx=0, out_last=0, out_re=0, out_im=0.
  - Bank contents are don't-care.
- in_ready = !full[wr_ptr].
  - Registered-state decode only; it has no combinational path from out_ready or in_valid.
- Capture: on in_valid & in_ready, all 14 inputs are written into bank[wr_ptr], full[wr_ptr] is set, and wr_ptr toggles.
- Readout:
  - out_valid = full[rd_ptr].
  - out_idx = cnt.
  - out_re/out_im are the mux of bank[rd_ptr] at bin cnt.
  - Bins 0 and 4 drive out_im = 0.
  - When out_valid=0, out_re/out_im/out_idx/out_last are driven to 0.
- Beat handshake (out_valid & out_ready):
  - If not the last beat, cnt increments.
  - If the last beat: cnt=0, full[rd_ptr] is cleared, and rd_ptr toggles.
- Hold: while out_valid & !out_ready, all out_* fields stay stable and cnt does not change.
- Latency: a frame captured at edge T presents bin 0 in the cycle after T. With out_ready held high, beats run on consecutive cycles with no bubbles between frames when the other bank is full.
- Simultaneous capture and last-beat retire in one edge: both take effect.
  - Legal, because they target different banks: wr_ptr != rd_ptr whenever both are allowed.
- Bank freed by a retire: its in_ready rises in the cycle after the last-beat handshake, never in the same cycle.
- Both banks full: in_ready=0. in_valid is ignored and the upstream must hold its frame.
- Wrap-around: the pointers toggle modulo 2; cnt wraps only via the last-beat rule.
  - HALF=1 never reaches idx 5..7.
- Reset mid-frame: the partial frame and any queued frame are discarded. Numbering restarts at bank 0, bin 0.
- No arithmetic is performed: data passes bit-exact from input to output.

Test Plan:
- Reset: assert rst for 2 cycles, then deassert → out_valid=0, in_ready=1, out_re=out_im=0.
- Single frame, N=4, HALF=0, out_ready=1:
  - Stimulus: y0=16'h0010, y4=16'hFFF0, yrk=k, yik=16'h0100+k. Capture at edge T.
  - Required response: 8 beats in cycles T+1..T+8 with out_idx 0..7. Beat 0 gives re=0010, im=0. Beat 4 gives re=FFF0, im=0. Beat 3 gives re=0003, im=0103. out_last is high only at idx 7, and out_valid=0 at T+9.
- Backpressure: drop out_ready for 4 cycles while idx=3 is presented → idx stays 3, data unchanged, out_valid=1. Readout resumes at idx 4 once out_ready returns to 1.
- Bank full: out_ready=0, and three frames A, B, C are offered back-to-back.
  - A and B are captured; in_ready=0 after B, and C is held.
  - Set out_ready=1: C is captured the cycle after A's last-beat handshake.
  - Output order is A, B, C, with 24 contiguous beats.
- HALF=1 single frame → 5 beats, idx 0..4, out_last high at idx 4, bank freed after idx 4.
- Reset mid-operation: assert rst during beat 5 of a frame while a second frame is queued.
  - Next cycle: out_valid=0, in_ready=1.
  - A new frame captured afterwards starts at idx 0 with its own data; no stale beats appear.

Source files
------------

// File: rtl/fft_out_unloader.sv
// Ping-pong frame buffer behind the 8-point FFT: captures a parallel y0..y7 frame
// in one handshake and streams it out one complex bin per beat in natural order.
module fft_out_unloader #(
    parameter int N    = 4,
    parameter bit HALF = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   y0,
    input  logic [2**N-1:0]   y4,
    input  logic [2**N-1:0]   yr1,
    input  logic [2**N-1:0]   yi1,
    input  logic [2**N-1:0]   yr2,
    input  logic [2**N-1:0]   yi2,
    input  logic [2**N-1:0]   yr3,
    input  logic [2**N-1:0]   yi3,
    input  logic [2**N-1:0]   yr5,
    input  logic [2**N-1:0]   yi5,
    input  logic [2**N-1:0]   yr6,
    input  logic [2**N-1:0]   yi6,
    input  logic [2**N-1:0]   yr7,
    input  logic [2**N-1:0]   yi7,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2**N-1:0]   out_re,
    output logic [2**N-1:0]   out_im,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int W = 2**N;
    localparam logic [2:0] LAST_IDX = HALF ? 3'd4 : 3'd7;

    // 14 words per bank: 8 real parts plus imag parts of bins 1-3 and 5-7 only.
    logic [W-1:0] re_q [2][8];
    logic [W-1:0] im_q [2][6];

    logic [1:0] full_q, full_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;

    logic         cap, beat, last, vld;
    logic [W-1:0] rd_re, rd_im;

    assign in_ready = !full_q[wr_ptr_q];
    assign vld      = full_q[rd_ptr_q];
    assign last     = (cnt_q == LAST_IDX);
    assign cap      = in_valid & in_ready;
    assign beat     = vld & out_ready;

    always_comb begin
        rd_re = re_q[rd_ptr_q][cnt_q];
        rd_im = '0;
        case (cnt_q)
            3'd1, 3'd2, 3'd3: rd_im = im_q[rd_ptr_q][cnt_q - 3'd1];
            3'd5, 3'd6, 3'd7: rd_im = im_q[rd_ptr_q][cnt_q - 3'd2];
            default:          rd_im = '0;
        endcase
    end

    // Everything is forced to zero while idle so downstream never sees stale bins.
    assign out_valid = vld;
    assign out_re    = vld ? rd_re : '0;
    assign out_im    = vld ? rd_im : '0;
    assign out_idx   = vld ? cnt_q : 3'd0;
    assign out_last  = vld & last;

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (cap) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        // A capture and a retire in the same edge always hit different banks.
        if (beat) begin
            if (last) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
                cnt_d            = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 3'd0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            re_q[wr_ptr_q][0] <= y0;
            re_q[wr_ptr_q][1] <= yr1;
            re_q[wr_ptr_q][2] <= yr2;
            re_q[wr_ptr_q][3] <= yr3;
            re_q[wr_ptr_q][4] <= y4;
            re_q[wr_ptr_q][5] <= yr5;
            re_q[wr_ptr_q][6] <= yr6;
            re_q[wr_ptr_q][7] <= yr7;
            im_q[wr_ptr_q][0] <= yi1;
            im_q[wr_ptr_q][1] <= yi2;
            im_q[wr_ptr_q][2] <= yi3;
            im_q[wr_ptr_q][3] <= yi5;
            im_q[wr_ptr_q][4] <= yi6;
            im_q[wr_ptr_q][5] <= yi7;
        end
    end
endmodule

// File: tb/tb_fft_out_unloader.sv
// Directed bench for fft_out_unloader: a full-frame instance and a HALF=1 instance
// share clock, reset and frame data but have their own handshakes.
module tb_fft_out_unloader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] y0, y4, yr1, yi1, yr2, yi2, yr3, yi3, yr5, yi5, yr6, yi6, yr7, yi7;
    logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic        in_ready0, out_last0, out_valid0, in_ready1, out_last1, out_valid1;
    logic [15:0] out_re0, out_im0, out_re1, out_im1;
    logic [2:0]  out_idx0, out_idx1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_out_unloader #(.N(4), .HALF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .y0(y0), .y4(y4),
        .yr1(yr1), .yi1(yi1), .yr2(yr2), .yi2(yi2), .yr3(yr3), .yi3(yi3),
        .yr5(yr5), .yi5(yi5), .yr6(yr6), .yi6(yi6), .yr7(yr7), .yi7(yi7),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .out_re(out_re0), .out_im(out_im0), .out_idx(out_idx0), .out_last(out_last0),
        .out_valid(out_valid0), .out_ready(out_ready0));

    fft_out_unloader #(.N(4), .HALF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .y0(y0), .y4(y4),
        .yr1(yr1), .yi1(yi1), .yr2(yr2), .yi2(yi2), .yr3(yr3), .yi3(yi3),
        .yr5(yr5), .yi5(yi5), .yr6(yr6), .yi6(yi6), .yr7(yr7), .yi7(yi7),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .out_re(out_re1), .out_im(out_im1), .out_idx(out_idx1), .out_last(out_last1),
        .out_valid(out_valid1), .out_ready(out_ready1));

    // Frame tag 0 reproduces the hand-written frame: y0=0010, y4=FFF0, yrk=k, yik=0100+k.
    function automatic logic [15:0] exp_re(input logic [7:0] tag, input int k);
        if (k == 0) return {tag, 8'h10};
        if (k == 4) return 16'hFFF0 ^ {tag, 8'h00};
        return {tag, 8'h00} | 16'(k);
    endfunction

    function automatic logic [15:0] exp_im(input logic [7:0] tag, input int k);
        if (k == 0 || k == 4) return 16'h0000;
        return 16'h0100 + 16'(k) + {tag, 8'h00};
    endfunction

    task automatic drive_frame(input logic [7:0] tag);
        y0  = exp_re(tag, 0); y4  = exp_re(tag, 4);
        yr1 = exp_re(tag, 1); yi1 = exp_im(tag, 1);
        yr2 = exp_re(tag, 2); yi2 = exp_im(tag, 2);
        yr3 = exp_re(tag, 3); yi3 = exp_im(tag, 3);
        yr5 = exp_re(tag, 5); yi5 = exp_im(tag, 5);
        yr6 = exp_re(tag, 6); yi6 = exp_im(tag, 6);
        yr7 = exp_re(tag, 7); yi7 = exp_im(tag, 7);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one presented beat of dut0 against frame 'tag', bin k.
    task automatic beat0(input string nm, input logic [7:0] tag, input int k);
        vectors++;
        if (out_valid0 !== 1'b1 || out_idx0 !== 3'(k)) begin
            miscompares++;
            $display("FAIL %s beat%0d valid/idx got %b/%0d want 1/%0d", nm, k, out_valid0, out_idx0, k);
        end
        vectors++;
        if (out_re0 !== exp_re(tag, k) || out_im0 !== exp_im(tag, k)) begin
            miscompares++;
            $display("FAIL %s beat%0d data got %h/%h want %h/%h", nm, k, out_re0, out_im0,
                     exp_re(tag, k), exp_im(tag, k));
        end
        vectors++;
        if (out_last0 !== (k == 7)) begin
            miscompares++;
            $display("FAIL %s beat%0d last got %b want %b", nm, k, out_last0, (k == 7));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_re0 !== 16'h0 || out_im0 !== 16'h0 ||
            out_idx0 !== 3'd0 || out_last0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset0 got v=%b rdy=%b re=%h im=%h idx=%0d last=%b want 0 1 0 0 0 0",
                     out_valid0, in_ready0, out_re0, out_im0, out_idx0, out_last0);
        end
        vectors++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_re1 !== 16'h0 || out_im1 !== 16'h0) begin
            miscompares++;
            $display("FAIL reset1 got v=%b rdy=%b re=%h im=%h want 0 1 0 0",
                     out_valid1, in_ready1, out_re1, out_im1);
        end
    endtask

    task automatic test_single();
        out_ready0 = 1'b1;
        drive_frame(8'h00);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        vectors++;
        if (out_re0 !== 16'h0010 || out_im0 !== 16'h0000) begin
            miscompares++;
            $display("FAIL single bin0 got %h/%h want 0010/0000", out_re0, out_im0);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                vectors++;
                if (out_re0 !== 16'h0003 || out_im0 !== 16'h0103) begin
                    miscompares++;
                    $display("FAIL single bin3 got %h/%h want 0003/0103", out_re0, out_im0);
                end
            end
            if (k == 4) begin
                vectors++;
                if (out_re0 !== 16'hFFF0 || out_im0 !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL single bin4 got %h/%h want FFF0/0000", out_re0, out_im0);
                end
            end
            beat0("single", 8'h00, k);
            tick();
        end
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_re0 !== 16'h0) begin
            miscompares++;
            $display("FAIL single_end got v=%b rdy=%b re=%h want 0 1 0000", out_valid0, in_ready0, out_re0);
        end
    endtask

    task automatic test_backpressure();
        out_ready0 = 1'b1;
        drive_frame(8'h10);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat0("bp", 8'h10, k);
            tick();
        end
        out_ready0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            beat0("bp_hold", 8'h10, 3);
        end
        out_ready0 = 1'b1;
        for (int k = 3; k < 8; k++) begin
            beat0("bp_resume", 8'h10, k);
            tick();
        end
        vectors++;
        if (out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end valid got %b want 0", out_valid0);
        end
    endtask

    task automatic test_bank_full();
        logic [7:0] tags [3];
        tags[0] = 8'h20; tags[1] = 8'h21; tags[2] = 8'h22;
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        for (int f = 0; f < 3; f++) begin
            drive_frame(tags[f]);
            vectors++;
            if (in_ready0 !== (f < 2)) begin
                miscompares++;
                $display("FAIL full_offer%0d in_ready got %b want %b", f, in_ready0, (f < 2));
            end
            tick();
        end
        vectors++;
        if (in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_hold in_ready got %b want 0", in_ready0);
        end
        // C stays on the inputs; it may only be taken once A's bank retires.
        out_ready0 = 1'b1;
        for (int b = 0; b < 24; b++) begin
            beat0("full", tags[b / 8], b % 8);
            if (b <= 8) begin
                vectors++;
                if (in_ready0 !== (b == 8)) begin
                    miscompares++;
                    $display("FAIL full_rdy b%0d in_ready got %b want %b", b, in_ready0, (b == 8));
                end
            end
            tick();
            if (b == 8) in_valid0 = 1'b0;
        end
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL full_end got v=%b rdy=%b want 0 1", out_valid0, in_ready0);
        end
    endtask

    task automatic test_half();
        logic [7:0] t;
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        drive_frame(8'h30);
        tick();
        drive_frame(8'h40);
        tick();
        in_valid1 = 1'b0;
        vectors++;
        if (in_ready1 !== 1'b0) begin
            miscompares++;
            $display("FAIL half_full in_ready got %b want 0", in_ready1);
        end
        out_ready1 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            t = (f == 0) ? 8'h30 : 8'h40;
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (out_valid1 !== 1'b1 || out_idx1 !== 3'(k) || out_last1 !== (k == 4)) begin
                    miscompares++;
                    $display("FAIL half f%0d beat%0d v/idx/last got %b/%0d/%b want 1/%0d/%b",
                             f, k, out_valid1, out_idx1, out_last1, k, (k == 4));
                end
                vectors++;
                if (out_re1 !== exp_re(t, k) || out_im1 !== exp_im(t, k)) begin
                    miscompares++;
                    $display("FAIL half f%0d beat%0d data got %h/%h want %h/%h", f, k,
                             out_re1, out_im1, exp_re(t, k), exp_im(t, k));
                end
                if (f == 0) begin
                    vectors++;
                    if (in_ready1 !== 1'b0) begin
                        miscompares++;
                        $display("FAIL half beat%0d in_ready got %b want 0", k, in_ready1);
                    end
                end
                tick();
            end
            vectors++;
            if (in_ready1 !== 1'b1) begin
                miscompares++;
                $display("FAIL half_freed f%0d in_ready got %b want 1", f, in_ready1);
            end
        end
        vectors++;
        if (out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL half_end valid got %b want 0", out_valid1);
        end
    endtask

    task automatic test_reset_mid();
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        drive_frame(8'h50);
        tick();
        drive_frame(8'h60);
        tick();
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        repeat (5) tick();
        beat0("mid_pre", 8'h50, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_idx0 !== 3'd0 || out_re0 !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_rst got v=%b rdy=%b idx=%0d re=%h want 0 1 0 0000",
                     out_valid0, in_ready0, out_idx0, out_re0);
        end
        drive_frame(8'h70);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat0("mid_new", 8'h70, k);
            tick();
        end
        vectors++;
        if (out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stale valid got %b idx=%0d re=%h want 0", out_valid0, out_idx0, out_re0);
        end
    endtask

    initial begin
        drive_frame(8'h00);
        test_reset();
        test_single();
        test_backpressure();
        test_bank_full();
        test_half();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
